// File: rtl/head_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module : head_sram_pkg
// Write-mode encoding, default geometry and lane-enable helpers.
// Rev    : 1.0
// ============================================================================
package head_sram_pkg;

  typedef enum logic [1:0] {
    WM_FULL  = 2'd0,
    WM_SLICE = 2'd1,
    WM_GROUP = 2'd2,
    WM_RSVD  = 2'd3
  } wmode_e;

  localparam int DEF_DATA_WIDTH = 128;
  localparam int DEF_BANK_DEPTH = 32;
  localparam int DEF_SLICE_BIT  = 8;
  localparam int DEF_GROUP      = 4;
  localparam int DEF_IF_WIDTH   = 16;
  localparam int DEF_TAG_W      = 4;

  localparam int NSLICE = DEF_DATA_WIDTH / DEF_SLICE_BIT;
  localparam int NIFW   = DEF_DATA_WIDTH / DEF_IF_WIDTH;

  function automatic logic wmode_illegal(input wmode_e mode, input int sel,
                                         input int group, input int nslice);
    logic bad;
    case (mode)
      WM_FULL:  bad = 1'b0;
      WM_SLICE: bad = (sel >= nslice);
      WM_GROUP: bad = ((sel % group) != 0) || ((sel + group) > nslice);
      default:  bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Per-slice write enable; an illegal request enables nothing.
  function automatic logic lane_en(input wmode_e mode, input int sel, input int lane,
                                   input int group, input int nslice);
    logic en;
    en = 1'b0;
    if (!wmode_illegal(mode, sel, group, nslice)) begin
      case (mode)
        WM_FULL:  en = (lane < nslice);
        WM_SLICE: en = (lane == sel);
        WM_GROUP: en = (lane >= sel) && (lane < (sel + group));
        default:  en = 1'b0;
      endcase
    end
    return en;
  endfunction

endpackage
`default_nettype wire

// File: rtl/head_sram_arb_if.sv
`default_nettype none
// ============================================================================
// Module : head_sram_arb_if
// Host and core request/response bundle of the head SRAM front-end.
// Rev    : 1.0
// ============================================================================
interface head_sram_arb_if
  import head_sram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BANK_DEPTH = DEF_BANK_DEPTH,
  parameter int SLICE_BIT  = DEF_SLICE_BIT,
  parameter int IF_WIDTH   = DEF_IF_WIDTH,
  parameter int TAG_W      = DEF_TAG_W
);
  localparam int ROW_W = $clog2(BANK_DEPTH);
  localparam int SEL_W = $clog2(DATA_WIDTH / SLICE_BIT);
  localparam int IFA_W = ROW_W + $clog2(DATA_WIDTH / IF_WIDTH);

  logic [IFA_W-1:0]       if_addr;
  logic                   if_wen;
  logic [IF_WIDTH-1:0]    if_wdata;
  logic                   if_ren;
  logic [IF_WIDTH-1:0]    if_rdata;
  logic                   if_rvalid;
  logic [SEL_W+ROW_W-1:0] core_waddr;
  logic [1:0]             core_wmode;
  logic [DATA_WIDTH-1:0]  core_wdata;
  logic                   core_wvalid;
  logic                   core_wready;
  logic [ROW_W-1:0]       core_raddr;
  logic [TAG_W-1:0]       core_rtag;
  logic                   core_rvalid_in;
  logic                   core_rready;
  logic [DATA_WIDTH-1:0]  core_rdata;
  logic [TAG_W-1:0]       core_rtag_out;
  logic                   core_rvalid;
  logic                   err;
  logic                   err_clr;

  modport slave (
    input  if_addr, if_wen, if_wdata, if_ren,
    input  core_waddr, core_wmode, core_wdata, core_wvalid,
    input  core_raddr, core_rtag, core_rvalid_in, err_clr,
    output if_rdata, if_rvalid, core_wready, core_rready,
    output core_rdata, core_rtag_out, core_rvalid, err
  );

  modport master (
    output if_addr, if_wen, if_wdata, if_ren,
    output core_waddr, core_wmode, core_wdata, core_wvalid,
    output core_raddr, core_rtag, core_rvalid_in, err_clr,
    input  if_rdata, if_rvalid, core_wready, core_rready,
    input  core_rdata, core_rtag_out, core_rvalid, err
  );

endinterface
`default_nettype wire

// File: rtl/head_sram_wmask.sv
`default_nettype none
// ============================================================================
// Module : head_sram_wmask
// Core write mode/slice select to bit-enable, aligned data and illegal flag.
// Rev    : 1.0
// ============================================================================
module head_sram_wmask
  import head_sram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SLICE_BIT  = DEF_SLICE_BIT,
  parameter int GROUP      = DEF_GROUP,
  parameter int SEL_W      = $clog2(NSLICE)
) (
  input  logic [1:0]            mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] bwe,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  illegal
);
  localparam int SLICES = DATA_WIDTH / SLICE_BIT;

  wmode_e mode_e;
  assign mode_e  = wmode_e'(mode);
  assign illegal = wmode_illegal(mode_e, int'(sel), GROUP, SLICES);

  generate
    for (genvar s = 0; s < SLICES; s++) begin : g_slice
      assign bwe[s*SLICE_BIT +: SLICE_BIT] =
        {SLICE_BIT{lane_en(mode_e, int'(sel), s, GROUP, SLICES)}};
    end
  endgenerate

  // Slice and group payloads arrive in the LSBs and are moved up to their lane.
  assign data_out = (mode_e == WM_FULL) ? data_in : (data_in << (int'(sel) * SLICE_BIT));

endmodule
`default_nettype wire

// File: rtl/mem_dp_sky130_wrapper.sv
`default_nettype none
// ============================================================================
// Module : mem_dp_sky130_wrapper
// Dual-port macro model: one bit-masked write port, one registered read port.
// Rev    : 1.0
// ============================================================================
module mem_dp_sky130_wrapper #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 32,
  parameter int BWE        = 1,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wen,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] bwe,
  input  logic                  ren,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] wmask;

  generate
    if (BWE != 0) begin : g_bwe
      assign wmask = bwe;
    end else begin : g_no_bwe
      assign wmask = '1;
    end
  endgenerate

  // A read colliding with a write returns the pre-write contents.
  always_ff @(posedge clk) begin
    if (wen) mem_q[waddr] <= (mem_q[waddr] & ~wmask) | (wdata & wmask);
    if (ren) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/head_sram_arb.sv
`default_nettype none
// ============================================================================
// Module : head_sram_arb
// Head SRAM front-end: host-priority arbitration, masked writes, tagged reads.
// Rev    : 1.0
// ============================================================================
module head_sram_arb
  import head_sram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BANK_DEPTH = DEF_BANK_DEPTH,
  parameter int SLICE_BIT  = DEF_SLICE_BIT,
  parameter int GROUP      = DEF_GROUP,
  parameter int IF_WIDTH   = DEF_IF_WIDTH,
  parameter int TAG_W      = DEF_TAG_W
) (
  input  logic           clk,
  input  logic           rstn,
  head_sram_arb_if.slave bus
);
  localparam int NSL   = DATA_WIDTH / SLICE_BIT;
  localparam int NWORD = DATA_WIDTH / IF_WIDTH;
  localparam int ROW_W = $clog2(BANK_DEPTH);
  localparam int SEL_W = $clog2(NSL);
  localparam int WRD_W = $clog2(NWORD);

  logic host_w, host_r, core_wacc, core_racc;
  assign host_w           = bus.if_wen;
  assign host_r           = bus.if_ren;
  assign bus.core_wready  = ~bus.if_wen;
  assign bus.core_rready  = ~bus.if_ren;
  assign core_wacc        = bus.core_wvalid & ~bus.if_wen;
  assign core_racc        = bus.core_rvalid_in & ~bus.if_ren;

  logic [WRD_W-1:0]      host_word;
  logic [ROW_W-1:0]      host_row;
  logic [DATA_WIDTH-1:0] host_bwe, host_wdata;
  assign host_word  = bus.if_addr[WRD_W-1:0];
  assign host_row   = bus.if_addr[ROW_W+WRD_W-1:WRD_W];
  assign host_wdata = {NWORD{bus.if_wdata}};

  generate
    for (genvar w = 0; w < NWORD; w++) begin : g_host_lane
      assign host_bwe[w*IF_WIDTH +: IF_WIDTH] = {IF_WIDTH{host_word == WRD_W'(w)}};
    end
  endgenerate

  logic [SEL_W-1:0]      core_sel;
  logic [ROW_W-1:0]      core_wrow;
  logic [DATA_WIDTH-1:0] core_bwe, core_wdata;
  logic                  core_illegal;
  assign core_sel  = bus.core_waddr[SEL_W+ROW_W-1:ROW_W];
  assign core_wrow = bus.core_waddr[ROW_W-1:0];

  head_sram_wmask #(
    .DATA_WIDTH (DATA_WIDTH),
    .SLICE_BIT  (SLICE_BIT),
    .GROUP      (GROUP),
    .SEL_W      (SEL_W)
  ) u_wmask (
    .mode     (bus.core_wmode),
    .sel      (core_sel),
    .data_in  (bus.core_wdata),
    .bwe      (core_bwe),
    .data_out (core_wdata),
    .illegal  (core_illegal)
  );

  // Write stage, read request stage, read return stage.
  logic                  wen_q, wen_d;
  logic [ROW_W-1:0]      wrow_q, wrow_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, bwe_q, bwe_d;
  logic                  err_q, err_d;
  logic                  rd_vld_q, rd_vld_d, rd_host_q, rd_host_d;
  logic [ROW_W-1:0]      rd_row_q, rd_row_d;
  logic [WRD_W-1:0]      rd_word_q, rd_word_d;
  logic [TAG_W-1:0]      rd_tag_q, rd_tag_d;
  logic                  rv_host_q, rv_host_d, rv_core_q, rv_core_d;
  logic [WRD_W-1:0]      rv_word_q, rv_word_d;
  logic [TAG_W-1:0]      rv_tag_q, rv_tag_d;
  logic [DATA_WIDTH-1:0] byp_bwe_q, byp_bwe_d, byp_data_q, byp_data_d;

  always_comb begin
    wen_d   = 1'b0;
    wrow_d  = '0;
    wdata_d = '0;
    bwe_d   = '0;
    if (host_w) begin
      wen_d   = 1'b1;
      wrow_d  = host_row;
      wdata_d = host_wdata & host_bwe;
      bwe_d   = host_bwe;
    end else if (core_wacc && !core_illegal) begin
      wen_d   = 1'b1;
      wrow_d  = core_wrow;
      wdata_d = core_wdata & core_bwe;
      bwe_d   = core_bwe;
    end

    err_d = err_q;
    if (core_wacc && core_illegal) err_d = 1'b1;
    else if (bus.err_clr)          err_d = 1'b0;

    rd_vld_d  = host_r | core_racc;
    rd_host_d = host_r;
    rd_row_d  = host_r ? host_row : bus.core_raddr;
    rd_word_d = host_word;
    rd_tag_d  = bus.core_rtag;

    rv_host_d  = rd_vld_q & rd_host_q;
    rv_core_d  = rd_vld_q & ~rd_host_q;
    rv_word_d  = rd_word_q;
    rv_tag_d   = rd_tag_q;
    // The macro returns pre-write data on a row collision; patch it on return.
    byp_bwe_d  = (wen_q && rd_vld_q && (wrow_q == rd_row_q)) ? bwe_q : '0;
    byp_data_d = wdata_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wen_q      <= 1'b0;
      wrow_q     <= '0;
      wdata_q    <= '0;
      bwe_q      <= '0;
      err_q      <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_host_q  <= 1'b0;
      rd_row_q   <= '0;
      rd_word_q  <= '0;
      rd_tag_q   <= '0;
      rv_host_q  <= 1'b0;
      rv_core_q  <= 1'b0;
      rv_word_q  <= '0;
      rv_tag_q   <= '0;
      byp_bwe_q  <= '0;
      byp_data_q <= '0;
    end else begin
      wen_q      <= wen_d;
      wrow_q     <= wrow_d;
      wdata_q    <= wdata_d;
      bwe_q      <= bwe_d;
      err_q      <= err_d;
      rd_vld_q   <= rd_vld_d;
      rd_host_q  <= rd_host_d;
      rd_row_q   <= rd_row_d;
      rd_word_q  <= rd_word_d;
      rd_tag_q   <= rd_tag_d;
      rv_host_q  <= rv_host_d;
      rv_core_q  <= rv_core_d;
      rv_word_q  <= rv_word_d;
      rv_tag_q   <= rv_tag_d;
      byp_bwe_q  <= byp_bwe_d;
      byp_data_q <= byp_data_d;
    end
  end

  logic [DATA_WIDTH-1:0] mac_rdata, line;

  mem_dp_sky130_wrapper #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BANK_DEPTH),
    .BWE        (1),
    .ADDR_W     (ROW_W)
  ) u_mem (
    .clk   (clk),
    .wen   (wen_q),
    .waddr (wrow_q),
    .wdata (wdata_q),
    .bwe   (bwe_q),
    .ren   (rd_vld_q),
    .raddr (rd_row_q),
    .rdata (mac_rdata)
  );

  assign line              = (mac_rdata & ~byp_bwe_q) | (byp_data_q & byp_bwe_q);
  assign bus.if_rvalid     = rv_host_q;
  assign bus.if_rdata      = rv_host_q ? line[rv_word_q*IF_WIDTH +: IF_WIDTH] : '0;
  assign bus.core_rvalid   = rv_core_q;
  assign bus.core_rdata    = rv_core_q ? line : '0;
  assign bus.core_rtag_out = rv_core_q ? rv_tag_q : '0;
  assign bus.err           = err_q;

endmodule
`default_nettype wire

// File: tb/tb_head_sram_arb.sv
`default_nettype none
// ============================================================================
// Module : tb_head_sram_arb
// Directed self-checking bench for the head SRAM front-end.
// Rev    : 1.0
// ============================================================================
module tb_head_sram_arb;
  import head_sram_pkg::*;

  localparam logic [127:0] P3     = 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff;
  localparam logic [127:0] P3_NEW = 128'h0011_2233_1234_6677_8899_aabb_ccdd_eeff;
  localparam logic [127:0] P7     = 128'hfedc_ba98_7654_3210_0f1e_2d3c_4b5a_6978;
  localparam logic [127:0] L_AB   = 128'h0000_0000_0000_0000_ab00_0000_0000_0000;
  localparam logic [127:0] L_GRP  = 128'h0000_0000_0000_0000_dead_beef_0000_0000;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  head_sram_arb_if bus ();
  head_sram_arb dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic idle();
    bus.if_addr        = '0;
    bus.if_wen         = 1'b0;
    bus.if_wdata       = '0;
    bus.if_ren         = 1'b0;
    bus.core_waddr     = '0;
    bus.core_wmode     = WM_FULL;
    bus.core_wdata     = '0;
    bus.core_wvalid    = 1'b0;
    bus.core_raddr     = '0;
    bus.core_rtag      = '0;
    bus.core_rvalid_in = 1'b0;
    bus.err_clr        = 1'b0;
  endtask

  task automatic host_write(input logic [4:0] row, input logic [2:0] word, input logic [15:0] d);
    bus.if_addr  = {row, word};
    bus.if_wdata = d;
    bus.if_wen   = 1'b1;
    step();
    bus.if_wen   = 1'b0;
  endtask

  task automatic core_write(input logic [1:0] mode, input logic [3:0] sel,
                            input logic [4:0] row, input logic [127:0] d);
    bus.core_waddr  = {sel, row};
    bus.core_wmode  = mode;
    bus.core_wdata  = d;
    bus.core_wvalid = 1'b1;
    step();
    bus.core_wvalid = 1'b0;
  endtask

  task automatic host_read(input logic [4:0] row, input logic [2:0] word,
                           input logic [15:0] exp, input string tag);
    bus.if_addr = {row, word};
    bus.if_ren  = 1'b1;
    step();
    bus.if_ren  = 1'b0;
    chk({tag, "_t1_valid"}, bus.if_rvalid, 0);
    step();
    chk({tag, "_t2_valid"}, bus.if_rvalid, 1);
    chk({tag, "_data"}, bus.if_rdata, exp);
    step();
    chk({tag, "_t3_valid"}, bus.if_rvalid, 0);
  endtask

  task automatic core_read(input logic [4:0] row, input logic [3:0] tag_in,
                           input logic [127:0] exp, input string tag);
    bus.core_raddr     = row;
    bus.core_rtag      = tag_in;
    bus.core_rvalid_in = 1'b1;
    step();
    bus.core_rvalid_in = 1'b0;
    chk({tag, "_t1_valid"}, bus.core_rvalid, 0);
    step();
    chk({tag, "_t2_valid"}, bus.core_rvalid, 1);
    chk({tag, "_data"}, bus.core_rdata, exp);
    chk({tag, "_tag"}, bus.core_rtag_out, tag_in);
    step();
    chk({tag, "_t3_valid"}, bus.core_rvalid, 0);
  endtask

  initial begin
    idle();
    #2 rstn = 1'b0;
    step();
    step();
    chk("rst_if_rvalid", bus.if_rvalid, 0);
    chk("rst_core_rvalid", bus.core_rvalid, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_if_rdata", bus.if_rdata, 0);
    chk("rst_core_rdata", bus.core_rdata, 0);
    chk("rst_core_rtag", bus.core_rtag_out, 0);
    rstn = 1'b1;
    step();

    // Host word write into a known line, then host and core readback.
    core_write(WM_FULL, 4'd0, 5'd3, P3);
    host_write(5'd3, 3'd5, 16'h1234);
    host_read(5'd3, 3'd5, 16'h1234, "hrd_w5");
    host_read(5'd3, 3'd4, 16'h6677, "hrd_w4");
    core_read(5'd3, 4'h1, P3_NEW, "crd_row3");

    // Single slice and aligned group writes.
    core_write(WM_FULL, 4'd0, 5'd2, '0);
    core_write(WM_SLICE, 4'd7, 5'd2, 128'hab);
    core_read(5'd2, 4'h9, L_AB, "crd_slice");
    core_write(WM_FULL, 4'd0, 5'd5, '0);
    core_write(WM_GROUP, 4'd4, 5'd5, 128'hdead_beef);
    core_read(5'd5, 4'h2, L_GRP, "crd_group");

    // Misaligned group write is dropped and flags err.
    bus.core_waddr  = {4'd6, 5'd2};
    bus.core_wmode  = WM_GROUP;
    bus.core_wdata  = '1;
    bus.core_wvalid = 1'b1;
    #1 chk("err_pre", bus.err, 0);
    step();
    bus.core_wvalid = 1'b0;
    chk("err_set", bus.err, 1);
    core_read(5'd2, 4'h3, L_AB, "crd_dropped");
    chk("err_sticky", bus.err, 1);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    chk("err_clr", bus.err, 0);
    bus.core_wmode  = WM_RSVD;
    bus.core_wvalid = 1'b1;
    bus.err_clr     = 1'b1;
    step();
    bus.core_wvalid = 1'b0;
    bus.err_clr     = 1'b0;
    chk("err_set_over_clr", bus.err, 1);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    chk("err_clr2", bus.err, 0);
    core_read(5'd2, 4'h4, L_AB, "crd_rsvd_dropped");

    // Host and core write in the same cycle; core holds and wins next cycle.
    bus.if_addr     = {5'd6, 3'd0};
    bus.if_wdata    = 16'h5555;
    bus.if_wen      = 1'b1;
    bus.core_waddr  = {4'd0, 5'd7};
    bus.core_wmode  = WM_FULL;
    bus.core_wdata  = P7;
    bus.core_wvalid = 1'b1;
    #1 chk("wready_lose", bus.core_wready, 0);
    step();
    bus.if_wen = 1'b0;
    #1 chk("wready_win", bus.core_wready, 1);
    step();
    bus.core_wvalid = 1'b0;
    host_read(5'd6, 3'd0, 16'h5555, "hrd_conflict");
    core_read(5'd7, 4'ha, P7, "crd_conflict");

    // Same-row write and read in the macro cycle: new data must win.
    core_write(WM_FULL, 4'd0, 5'd4, '0);
    step();
    bus.core_waddr     = {4'd0, 5'd4};
    bus.core_wmode     = WM_FULL;
    bus.core_wdata     = '1;
    bus.core_wvalid    = 1'b1;
    bus.core_raddr     = 5'd4;
    bus.core_rtag      = 4'h5;
    bus.core_rvalid_in = 1'b1;
    step();
    bus.core_wvalid    = 1'b0;
    bus.core_rvalid_in = 1'b0;
    step();
    chk("byp_core_valid", bus.core_rvalid, 1);
    chk("byp_core_data", bus.core_rdata, '1);
    step();
    bus.if_addr  = {5'd4, 3'd2};
    bus.if_wdata = 16'h0f0f;
    bus.if_wen   = 1'b1;
    bus.if_ren   = 1'b1;
    step();
    bus.if_wen = 1'b0;
    bus.if_ren = 1'b0;
    step();
    chk("byp_host_valid", bus.if_rvalid, 1);
    chk("byp_host_data", bus.if_rdata, 16'h0f0f);
    step();
    host_read(5'd4, 3'd3, 16'hffff, "hrd_byp_neighbour");

    // Back-to-back core reads stream one per cycle.
    bus.core_raddr     = 5'd3;
    bus.core_rtag      = 4'h1;
    bus.core_rvalid_in = 1'b1;
    step();
    bus.core_raddr = 5'd7;
    bus.core_rtag  = 4'h2;
    step();
    bus.core_rvalid_in = 1'b0;
    chk("b2b_0_valid", bus.core_rvalid, 1);
    chk("b2b_0_tag", bus.core_rtag_out, 4'h1);
    chk("b2b_0_data", bus.core_rdata, P3_NEW);
    step();
    chk("b2b_1_valid", bus.core_rvalid, 1);
    chk("b2b_1_tag", bus.core_rtag_out, 4'h2);
    chk("b2b_1_data", bus.core_rdata, P7);
    step();
    chk("b2b_idle", bus.core_rvalid, 0);

    // Reset after the second of four streamed reads kills everything in flight.
    bus.core_raddr     = 5'd3;
    bus.core_rtag      = 4'h0;
    bus.core_rvalid_in = 1'b1;
    step();
    bus.core_raddr = 5'd7;
    bus.core_rtag  = 4'h1;
    step();
    chk("rstmid_tag0_valid", bus.core_rvalid, 1);
    chk("rstmid_tag0_tag", bus.core_rtag_out, 4'h0);
    bus.core_raddr = 5'd5;
    bus.core_rtag  = 4'h2;
    rstn = 1'b0;
    #1;
    chk("rstmid_valid_now", bus.core_rvalid, 0);
    chk("rstmid_tag_now", bus.core_rtag_out, 0);
    step();
    bus.core_raddr     = 5'd2;
    bus.core_rtag      = 4'h3;
    step();
    chk("rstmid_held_valid", bus.core_rvalid, 0);
    bus.core_rvalid_in = 1'b0;
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rstmid_after_valid", bus.core_rvalid, 0);
    end
    core_read(5'd7, 4'hc, P7, "crd_post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/head_sram_arb.md
Name: head_sram_arb

Overview:
- Next-generation head SRAM front-end wrapping one dual-port macro (mem_dp_sky130_wrapper, BWE=1) per head.
- Serves two masters: the core datapath (wide line writes in full/slice/group modes, line reads) and the narrow host interface (IF_WIDTH-bit words).
- Adds explicit ready handshakes for core requests losing arbitration, tagged read-valid pipelines, same-cycle write-to-read bypass, and a sticky error flag for illegal write modes.
- Width, depth, slice size and interface width are all parametrised.

Parameters:
- DATA_WIDTH, 128, macro line width in bits.
- BANK_DEPTH, 32, macro rows.
- SLICE_BIT, 8, bits per slice; NSLICE = DATA_WIDTH/SLICE_BIT.
- GROUP, 4, slices per group write; must divide NSLICE.
- IF_WIDTH, 16, host word width; must divide DATA_WIDTH; NIFW = DATA_WIDTH/IF_WIDTH.
- ROW_W, $clog2(BANK_DEPTH), derived.
- SEL_W, $clog2(NSLICE), derived.
- IFA_W, ROW_W+$clog2(NIFW), derived.
- TAG_W, 4, core read tag width.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset.
- if_addr  in  IFA_W  {row, word index}.
- if_wen  in  1  host write.
- if_wdata  in  IF_WIDTH  host write data.
- if_ren  in  1  host read.
- if_rdata  out  IF_WIDTH  host read data.
- if_rvalid  out  1  host read data valid.
- core_waddr  in  SEL_W+ROW_W  {slice select, row}.
- core_wmode  in  2  0 full line, 1 single slice, 2 group, 3 reserved.
- core_wdata  in  DATA_WIDTH  write data; slice/group data in the LSBs.
- core_wvalid  in  1  write request.
- core_wready  out  1  write accepted.
- core_raddr  in  ROW_W  read row.
- core_rtag  in  TAG_W  tag returned with the data.
- core_rvalid_in  in  1  read request.
- core_rready  out  1  read accepted.
- core_rdata  out  DATA_WIDTH  read line.
- core_rtag_out  out  TAG_W  tag of the returned line.
- core_rvalid  out  1  read data valid.
- err  out  1  sticky illegal-write flag.
- err_clr  in  1  clears err.

Behaviour:
- Clocking and reset: single clock clk; reset rstn is asynchronous, active-low.
- Reset values: if_rvalid=0, core_rvalid=0, err=0, all request registers and in-flight pipelines cleared; if_rdata, core_rdata and core_rtag_out read 0.
- Data gating: if_rdata, core_rdata and core_rtag_out are forced to 0 whenever their valid is low.
- Arbitration, per macro port, independently for write and read: host has fixed priority.
  - core_wready = ~if_wen and core_rready = ~if_ren (combinational).
  - A core request transfers on valid&ready. The core must hold its request stable while ready is low.
- Write path, stage 1 (registered):
  - Host write: accepted word sets bwe[word*IF_WIDTH +: IF_WIDTH] to all-ones and data into the same lane; all other bwe bits are 0.
  - Core mode 0: bwe all-ones.
  - Core mode 1: slice sel gets core_wdata[SLICE_BIT-1:0].
  - Core mode 2: GROUP slices starting at sel get core_wdata[GROUP*SLICE_BIT-1:0]; sel must be a multiple of GROUP.
  - Mode 3 or misaligned group: the write is dropped (macro wen=0) and err sets on the following edge.
- Write path, stage 2: the registered wen, row, data and bwe drive the macro write port. Write latency is 1 cycle from acceptance to the macro port.
- Read path: an accepted request registers the row and, for core reads, the tag.
  - The macro is driven in cycle T+1; data returns in cycle T+2 with a one-cycle valid pulse.
  - Host: if_rdata = line[word*IF_WIDTH +: IF_WIDTH], where word is the registered word index from T.
  - Back-to-back reads are fully pipelined: one per cycle, no bubbles.
- Bypass: if the macro write and read ports address the same row in the same cycle, the returned line is macro data with the bwe-enabled bits replaced by the write data (new data wins).
- err: set has priority over err_clr in the same cycle.
- Reset mid-operation: all in-flight reads and writes are discarded and no valid is produced afterwards. Macro contents are untouched.

Decomposition:
- Shared package head_sram_pkg:
  - write-mode enum (WM_FULL, WM_SLICE, WM_GROUP, WM_RSVD);
  - localparam helpers NSLICE, NIFW;
  - a function building the bwe/data lane masks from mode and sel.
- Sub-module head_sram_wmask: combinational mode/sel to {bwe, data, illegal}.
- Macro: reuse the existing mem_dp_sky130_wrapper.

Test Plan:
- Host write of 0x1234 at row 3 word 5, then host read at row 3 word 5: if_rvalid pulses exactly 2 cycles after the read request, with if_rdata=0x1234; other lanes of row 3 are unchanged.
- Core mode 1 write, sel 7, row 2, data 0xAB; then a core read of row 2 with tag 0x9: core_rdata[63:56]=0xAB, core_rtag_out=0x9, core_rvalid 2 cycles after acceptance.
- Core mode 2 write with sel=6: no macro write, err=1 on the next cycle; err_clr -> err=0.
- if_wen and core_wvalid in the same cycle: core_wready=0 that cycle, and the host write lands. The core holds its request and is accepted on the next cycle; both writes end up in memory.
- Full-line write of 0xFF..FF to row 4 while the macro read port reads row 4 in the same cycle: the returned line is 0xFF..FF (bypass).
- Four back-to-back core reads with tags 0..3 and rstn pulsed low after the second acceptance: only the tags already returned appear, and core_rvalid=0 after reset.
